// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: flip-flop FIFO with flush; flush wins over push, head reads zero when empty
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter type T = logic [63:0],
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output T              head_o
);
  T              mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  // pointer and occupancy next state; flush discards everything, including a same-cycle push
  always_comb begin
    rd_d    = flush_i ? '0 : pop_i ? nxt(rd_q) : rd_q;
    wr_d    = flush_i ? '0 : push_i ? nxt(wr_q) : wr_q;
    count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
  end

  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // storage needs no reset: the head is masked while empty
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer for a 1-cycle-latency ROM with buffered valid/ready output
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ROM_SIZE = 64,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);
  localparam int AW = $clog2(ROM_SIZE);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q, pc_d, ipc_q, ipc_d;
  logic          inflight_q, inflight_d;
  logic          pop, issue, empty;
  logic [CW-1:0] count;
  fetch_entry_t  head;

  assign rom_addr  = 32'(pc_q[AW+1:2]);
  assign out_valid = !empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign pop       = out_valid && out_ready;
  // a slot freed by this cycle's pop can be reused by this cycle's issue
  assign issue     = !redirect_valid && (int'(count) + int'(inflight_q) < DEPTH + int'(pop));

  // next PC and in-flight tracking; a redirect cancels the outstanding read
  always_comb begin
    pc_d       = redirect_valid ? (redirect_pc & ~32'd3) : issue ? pc_q + 32'(INSTR_BYTES) : pc_q;
    inflight_d = issue;
    ipc_d      = issue ? pc_q : ipc_q;
  end

  // PC and in-flight registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC & ~32'd3;
      inflight_q <= 1'b0;
      ipc_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      ipc_q      <= ipc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .data_i  ('{pc: ipc_q, instr: rom_rd}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed and random-ready checks of the fetch controller against a ROM model
module tb_instr_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_addr, rom_rd, redirect_pc, out_instr, out_pc;
  logic        redirect_valid = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] rom [64];
  int          n_assert = 0, n_fail = 0;

  instr_fetch_ctrl #(.ROM_SIZE(64), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_rd         (rom_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) rom[i] = 32'hA0 + 32'(i);

  // registered ROM: data appears the cycle after the address
  always @(posedge clk) rom_rd <= rom[rom_addr[5:0]];

  function automatic logic [31:0] word(input logic [31:0] pc);
    return 32'hA0 + ((pc >> 2) & 32'd63);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " pc"}, out_pc, pc);
    check({tag, " instr"}, out_instr, word(pc));
  endtask

  // holds reset (with a competing redirect) then returns at the start of cycle 0
  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    out_ready = ready;
    step();
    step();
    rst = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  logic [31:0] exp_pc, prev_pc;
  logic        prev_stall;
  int          pops;

  initial begin
    // reset values, with redirect asserted during reset
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step();
    step();
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst instr", out_instr, 32'd0);
    check("rst pc", out_pc, 32'd0);
    check("rst rom_addr", rom_addr, 32'd0);

    // streaming from reset, one instruction per cycle
    do_reset(1'b1);
    check("c0 valid", 32'(out_valid), 32'd0);
    check("c0 rom_addr", rom_addr, 32'd0);
    step();
    check("c1 valid", 32'(out_valid), 32'd0);
    step();
    for (int k = 0; k < 8; k++) begin
      check_out("stream", 32'(4 * k));
      step();
    end

    // backpressure from cycle 0
    do_reset(1'b0);
    step();
    step();
    for (int k = 2; k < 12; k++) begin
      check_out("stall", 32'h0);
      if (k < 11) step();
    end
    check("stall rom_addr", rom_addr, 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_out("resume", 32'(4 * k));
      step();
    end

    // redirect at cycle 5 with ready high
    do_reset(1'b1);
    for (int k = 0; k < 5; k++) step();
    check_out("pre-redir", 32'hC);
    redirect(32'h20);
    check("redir c6 valid", 32'(out_valid), 32'd0);
    check("redir c6 rom_addr", rom_addr, 32'd8);
    step();
    check("redir c7 valid", 32'(out_valid), 32'd0);
    step();
    check_out("redir c8", 32'h20);
    step();
    check_out("redir c9", 32'h24);

    // redirect to an unaligned PC while the FIFO is full and stalled
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) step();
    check_out("full", 32'h0);
    redirect(32'h43);
    check("full c6 valid", 32'(out_valid), 32'd0);
    check("full c6 rom_addr", rom_addr, 32'h10);
    step();
    check("full c7 valid", 32'(out_valid), 32'd0);
    step();
    check_out("full c8", 32'h40);
    step();
    check_out("full hold", 32'h40);

    // back-to-back redirects: the later target wins
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) step();
    check_out("b2b c4", 32'h8);
    redirect(32'h10);
    check("b2b c5 valid", 32'(out_valid), 32'd0);
    redirect(32'h30);
    check("b2b c6 valid", 32'(out_valid), 32'd0);
    check("b2b c6 rom_addr", rom_addr, 32'd12);
    step();
    check("b2b c7 valid", 32'(out_valid), 32'd0);
    step();
    check_out("b2b c8", 32'h30);
    step();
    check_out("b2b c9", 32'h34);

    // ROM index wrap past the last word
    redirect(32'hFC);
    check("wrap rom_addr 63", rom_addr, 32'd63);
    step();
    check("wrap rom_addr 0", rom_addr, 32'd0);
    step();
    check_out("wrap fc", 32'hFC);
    step();
    check_out("wrap 100", 32'h100);

    // random ready against a contiguous-PC scoreboard
    do_reset(1'b0);
    exp_pc = 32'h0;
    prev_stall = 1'b0;
    prev_pc = 32'h0;
    pops = 0;
    for (int k = 0; k < 1000; k++) begin
      if (prev_stall) begin
        check("rnd hold valid", 32'(out_valid), 32'd1);
        check("rnd hold pc", out_pc, prev_pc);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        check("rnd pc", out_pc, exp_pc);
        check("rnd instr", out_instr, word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      prev_stall = out_valid && !out_ready;
      prev_pc = out_pc;
      step();
    end
    check("rnd progress", 32'(pops > 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch sequencer that drives the registered-output instruction ROM (1-cycle read latency) and hands instructions to decode over a valid/ready interface.
- Keeps the PC and tracks the in-flight ROM read.
- Buffers responses in a small FIFO so backpressure never loses a ROM result.
- Squashes in-flight and buffered fetches on a redirect (branch/jump).
- Sits between the ROM and the decode stage of the multi-cycle/pipelined CPU exercises.

Parameters:
- ROM_SIZE, 64, ROM depth in 32-bit words; must be a power of two, ≥ 2.
- RESET_PC, 32'h0, byte address of the first fetch after reset.
- DEPTH, 2, response FIFO entries; must be ≥ 2 to sustain 1 instr/cycle.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- rom_addr  output  32  ROM word index. Zero-extended pc[$clog2(ROM_SIZE)+1:2], combinational from the PC register.
- rom_rd  input  32  ROM data; valid in the cycle after rom_addr was presented.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new byte PC; bits [1:0] are ignored (treated as 0).
- out_valid  output  1  out_instr/out_pc hold a valid fetched instruction.
- out_ready  input  1  consumer accepts this cycle.
- out_instr  output  32  instruction at FIFO head.
- out_pc  output  32  byte PC of out_instr.

Behaviour:
- Reset: clk and rst are the single clock and the synchronous, active-high reset; nothing else is reset-affected asynchronously.
  - pc = RESET_PC with bits [1:0] cleared; inflight = 0; FIFO empty.
  - out_valid = 0; out_instr = 0; out_pc = 0.
  - rst dominates redirect_valid and every other input.
- State:
  - pc register: next address to fetch.
  - inflight flag plus inflight_pc: one ROM read outstanding.
  - FIFO of {pc, instr}, DEPTH entries.
- Pop: pop = out_valid & out_ready. Head advances at the clock edge.
- Issue condition: issue = !redirect_valid & (fifo_count + inflight - pop < DEPTH).
  - On issue: inflight ≤ 1, inflight_pc ≤ pc, pc ≤ pc + 4 (wraps modulo 2^32).
  - On no issue: inflight ≤ 0, pc holds.
- Capture: when inflight = 1, {inflight_pc, rom_rd} is pushed into the FIFO that edge. The issue condition guarantees space, so a push to a full FIFO never occurs. Data on rom_rd when inflight = 0 is ignored.
- Outputs:
  - out_valid = FIFO non-empty; out_instr/out_pc = head entry.
  - All outputs come from registers; there is no combinational path from rom_rd to out_*.
  - Outputs stay stable while out_valid & !out_ready.
- Latency: first out_valid is seen 2 cycles after the rst-deasserted cycle.
  - Cycle 0: issue RESET_PC.
  - Cycle 1: rom_rd valid, push.
  - Cycle 2: out_valid.
  - With out_ready held high: one instruction per cycle, no bubbles.
- Backpressure: with out_ready low, issue stops once fifo_count + inflight = DEPTH. No ROM result is dropped; the PC resumes exactly after the last issued address.
- Redirect (cycle N, redirect_valid = 1):
  - A pop in cycle N still completes; the consumer owns that instruction.
  - All remaining FIFO entries and the in-flight read are discarded. The rom_rd arriving in N+1 for the squashed read is not pushed.
  - pc ≤ redirect_pc & ~3; no issue in cycle N.
  - Cycle N+1: out_valid = 0; rom_addr reflects redirect_pc; issue resumes.
  - Cycle N+3: first redirected instruction valid.
  - Back-to-back redirects: the last one wins.
- ROM index wraps modulo ROM_SIZE; the controller performs no range check.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - constant INSTR_BYTES = 4.
- Sub-module fetch_fifo, a flip-flop FIFO parameterised by DEPTH and the element type. It provides:
  - push, pop, flush, empty;
  - count of $clog2(DEPTH+1) bits;
  - head output.
  - flush has priority over push; pop within the same cycle as flush is allowed.

Test Plan:
- Reset release, out_ready = 1, program.hex words 0..7 = 0xA0..0xA7: out_valid rises in cycle 2, then out_pc = 0,4,8,… with out_instr = 0xA0,0xA1,… every cycle, no gaps.
- out_ready = 0 from cycle 0 for 10 cycles: out_valid = 1 from cycle 2 with out_pc = 0 held stable. rom_addr stops advancing after 2 issues. Releasing ready yields pc 0,4,8,… with no loss or duplicate.
- Redirect at cycle 5 to 0x20 with out_ready = 1: instruction popped in cycle 5 retained. Cycle 6 has out_valid = 0. Cycle 8 shows out_pc = 0x20, instr = word 8, then 0x24,…
- Redirect to 0x43 while the FIFO is full and out_ready = 0: FIFO flushed. First valid is out_pc = 0x40, instr = word 16, 3 cycles later.
- Redirect in two consecutive cycles (0x10 then 0x30): only 0x30 appears. No instruction from 0x10 or from the old stream is delivered.
- PC 0xFC with ROM_SIZE = 64: next rom_addr = 0 (index wrap) and out_pc = 0x100. Random out_ready against a scoreboard over 1000 cycles shows no drop or duplication.
